// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse cipher datapath.
// S-boxes are computed as multiplicative inverse plus affine map instead of a stored table.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NK         = 4;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Byte n sits at row n%4, column n/4; InvShiftRows pulls it from column (col - row) mod 4.
  function automatic int inv_shift_src(input int n);
    return 4 * (((n / 4) - (n % 4)) & 3) + (n % 4);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round; 'last' bypasses InvMixColumns for the closing round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_i,
  output logic [127:0] next_state_o
);

  always_comb begin
    logic [0:15][7:0] s;
    logic [0:15][7:0] a;
    logic [0:15][7:0] m;
    s = state_i;
    a = '0;
    m = '0;
    for (int n = 0; n < 16; n++) a[n] = inv_sbox(s[inv_shift_src(n)]);
    a = a ^ round_key_i;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        m[4*c+r] = gf_mul(8'h0e, a[4*c+r])           ^ gf_mul(8'h0b, a[4*c+(r+1)%4]) ^
                   gf_mul(8'h0d, a[4*c+(r+2)%4])     ^ gf_mul(8'h09, a[4*c+(r+3)%4]);
      end
    end
    next_state_o = last_i ? a : m;
  end

endmodule

// File: rtl/generate_key.sv
// Combinational AES-128 forward key expansion producing all eleven round keys.
module generate_key
  import aes_pkg::*;
(
  input  logic [127:0]        key_i,
  output logic [0:10][127:0]  round_keys_o
);

  always_comb begin
    logic [0:43][31:0] w;
    logic [31:0]       t;
    logic [7:0]        rcon;
    w    = '0;
    t    = '0;
    rcon = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = key_i[127 - 32*i -: 32];
    for (int i = NK; i < 4 * (NUM_ROUNDS + 1); i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t    = {sbox(t[23:16]) ^ rcon, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
        rcon = xtime(rcon);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int r = 0; r <= NUM_ROUNDS; r++)
      round_keys_o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock, start/done handshake.
// Optional AES_DEC_OVERRUN_ERR_EN adds a sticky 'err' flag for start requests while busy.
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] key_in,
  output logic [127:0] plaintext_out,
  output logic         busy,
  output logic         done
`ifdef AES_DEC_OVERRUN_ERR_EN
  ,
  output logic         err
`endif
);

  if (NUM_ROUNDS != aes_pkg::NUM_ROUNDS) begin : g_bad_rounds
    $error("aes_decrypt supports only NUM_ROUNDS = 10 (AES-128)");
  end

  logic [1:0]         rst_sync_q;
  logic               rst_int_n;
  state_e             state_q;
  logic [3:0]         rnd_q;
  logic [127:0]       ct_q, key_q, blk_q, pt_q;
  logic               busy_q, done_q;
  logic [0:10][127:0] rk;
  logic [127:0]       round_out;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  generate_key u_keys (
    .key_i        (key_q),
    .round_keys_o (rk)
  );

  aes_inv_round u_round (
    .state_i      (blk_q),
    .round_key_i  (rk[rnd_q]),
    .last_i       (state_q == FINAL),
    .next_state_o (round_out)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      ct_q    <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          ct_q    <= ciphertext_in;
          key_q   <= key_in;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          blk_q   <= ct_q ^ rk[NUM_ROUNDS];
          rnd_q   <= 4'(NUM_ROUNDS - 1);
          state_q <= ROUND;
        end
        ROUND: begin
          blk_q <= round_out;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) state_q <= FINAL;
        end
        FINAL: begin
          pt_q    <= round_out;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          rnd_q   <= 4'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_DEC_OVERRUN_ERR_EN
  logic err_q;

  // Sticky until a clean accepted start; an accepted start cannot coincide with busy.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                     err_q <= 1'b0;
    else if (start && busy_q)           err_q <= 1'b1;
    else if (start && state_q == IDLE)  err_q <= 1'b0;
  end
  assign err = err_q;
`endif

  assign plaintext_out = pt_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS vectors plus random blocks from a forward-cipher model.
module tb_aes_decrypt;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ciphertext_in = '0;
  logic [127:0] key_in = '0;
  logic [127:0] plaintext_out;
  logic         busy, done;
`ifdef AES_DEC_OVERRUN_ERR_EN
  logic         err;
`endif

  int passCnt  = 0;
  int checkCnt = 0;
  logic [7:0] sboxTbl [256];

  aes_decrypt dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ciphertext_in (ciphertext_in),
    .key_in        (key_in),
    .plaintext_out (plaintext_out),
    .busy          (busy),
    .done          (done)
`ifdef AES_DEC_OVERRUN_ERR_EN
    ,
    .err           (err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: forward AES-128 built from first principles.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p, aa;
    p = 0;
    aa = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return 8'(p);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sboxTbl[x] = s;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rcon;
    logic [127:0] res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127 - 8*(4*i+j) -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sboxTbl[w[i-1][(j+1)%4]];
        tmp[0] = tmp[0] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ w[n/4][n%4];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sboxTbl[s[n]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 10) begin
        for (int n = 0; n < 16; n++) t[n] = s[n];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++)
            s[4*c+row] = gmul(t[4*c+row], 8'h02) ^ gmul(t[4*c+(row+1)%4], 8'h03) ^
                         t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][n%4];
    end
    for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one block and waits (bounded) until done is observed; lat = cycles after start was sampled.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input bit scramble,
                           output int lat, output int busyCnt);
    ciphertext_in = ct;
    key_in = key;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    busyCnt = 0;
    while (!done && lat < 40) begin
      if (busy) busyCnt++;
      if (scramble) begin
        ciphertext_in = rand128();
        key_in = rand128();
      end
      step();
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checkCnt++;
    if (plaintext_out !== '0) $display("[TB] FAIL reset_pt got=%h want=0", plaintext_out); else passCnt++;
    checkCnt++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy); else passCnt++;
    checkCnt++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b want=0", done); else passCnt++;
`ifdef AES_DEC_OVERRUN_ERR_EN
    checkCnt++;
    if (err !== 1'b0) $display("[TB] FAIL reset_err got=%b want=0", err); else passCnt++;
`endif
    rst_n = 1'b1;
    repeat (4) step();
    checkCnt++;
    if (busy !== 1'b0) $display("[TB] FAIL idle_busy got=%b want=0", busy); else passCnt++;
  endtask

  task automatic test_vector_c1();
    int lat, bc;
    run_block(C1_CT, C1_KEY, 1'b0, lat, bc);
    checkCnt++;
    if (lat !== 11) $display("[TB] FAIL c1_latency got=%0d want=11", lat); else passCnt++;
    checkCnt++;
    if (bc !== 11) $display("[TB] FAIL c1_busy_cycles got=%0d want=11", bc); else passCnt++;
    checkCnt++;
    if (plaintext_out !== C1_PT) $display("[TB] FAIL c1_pt got=%h want=%h", plaintext_out, C1_PT); else passCnt++;
    step();
    checkCnt++;
    if (done !== 1'b0) $display("[TB] FAIL c1_done_pulse got=%b want=0", done); else passCnt++;
  endtask

  task automatic test_vector_b();
    int lat, bc;
    run_block(B_CT, B_KEY, 1'b0, lat, bc);
    checkCnt++;
    if (plaintext_out !== B_PT) $display("[TB] FAIL b_pt got=%h want=%h", plaintext_out, B_PT); else passCnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    bit holdOk;
    run_block(C1_CT, C1_KEY, 1'b0, lat, bc);
    ciphertext_in = Z_CT;
    key_in = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    gap = 1;
    holdOk = 1'b1;
    while (!done && gap < 40) begin
      if (plaintext_out !== C1_PT) holdOk = 1'b0;
      step();
      gap++;
    end
    checkCnt++;
    if (gap !== 12) $display("[TB] FAIL b2b_gap got=%0d want=12", gap); else passCnt++;
    checkCnt++;
    if (holdOk !== 1'b1) $display("[TB] FAIL b2b_hold got=%b want=1", holdOk); else passCnt++;
    checkCnt++;
    if (plaintext_out !== '0) $display("[TB] FAIL b2b_pt got=%h want=0", plaintext_out); else passCnt++;
    step();
  endtask

  task automatic test_start_while_busy();
    int doneCnt;
    bit errOk;
    ciphertext_in = B_CT;
    key_in = B_KEY;
    start = 1'b1;
    step();
    start = 1'b0;
    doneCnt = 0;
    errOk = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3 || k == 7) begin
        start = 1'b1;
        ciphertext_in = rand128();
      end
      step();
      start = 1'b0;
      if (done) doneCnt++;
`ifdef AES_DEC_OVERRUN_ERR_EN
      if (err !== (k >= 3)) errOk = 1'b0;
`endif
    end
    checkCnt++;
    if (doneCnt !== 1) $display("[TB] FAIL swb_done_count got=%0d want=1", doneCnt); else passCnt++;
    checkCnt++;
    if (plaintext_out !== B_PT) $display("[TB] FAIL swb_pt got=%h want=%h", plaintext_out, B_PT); else passCnt++;
`ifdef AES_DEC_OVERRUN_ERR_EN
    checkCnt++;
    if (errOk !== 1'b1) $display("[TB] FAIL swb_err got=%b want=1", errOk); else passCnt++;
`endif
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, doneCnt;
    ciphertext_in = C1_CT;
    key_in = C1_KEY;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    checkCnt++;
    if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got=%b want=0", busy); else passCnt++;
    checkCnt++;
    if (done !== 1'b0) $display("[TB] FAIL midrst_done got=%b want=0", done); else passCnt++;
    checkCnt++;
    if (plaintext_out !== '0) $display("[TB] FAIL midrst_pt got=%h want=0", plaintext_out); else passCnt++;
    repeat (2) step();
    rst_n = 1'b1;
    doneCnt = 0;
    repeat (25) begin
      step();
      if (done) doneCnt++;
    end
    checkCnt++;
    if (doneCnt !== 0) $display("[TB] FAIL midrst_no_done got=%0d want=0", doneCnt); else passCnt++;
    run_block(C1_CT, C1_KEY, 1'b0, lat, bc);
    checkCnt++;
    if (plaintext_out !== C1_PT || lat !== 11)
      $display("[TB] FAIL midrst_rerun got=%h lat=%0d want=%h lat=11", plaintext_out, lat, C1_PT);
    else passCnt++;
    step();
  endtask

  task automatic test_input_hold();
    int lat, bc;
    run_block(C1_CT, C1_KEY, 1'b1, lat, bc);
    checkCnt++;
    if (plaintext_out !== C1_PT) $display("[TB] FAIL hold_c1 got=%h want=%h", plaintext_out, C1_PT); else passCnt++;
    step();
    run_block(B_CT, B_KEY, 1'b1, lat, bc);
    checkCnt++;
    if (plaintext_out !== B_PT) $display("[TB] FAIL hold_b got=%h want=%h", plaintext_out, B_PT); else passCnt++;
    step();
  endtask

  task automatic test_random();
    logic [127:0] k, p, c;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      k = rand128();
      p = rand128();
      c = model_encrypt(p, k);
      run_block(c, k, (i % 2) == 1, lat, bc);
      checkCnt++;
      if (plaintext_out !== p || lat !== 11)
        $display("[TB] FAIL rand_%0d got=%h lat=%0d want=%h lat=11", i, plaintext_out, lat, p);
      else passCnt++;
      step();
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vector_c1();
    test_vector_b();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    test_input_hold();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
